// File: rtl/elevator_group_dispatcher_if.sv
// Purpose: per-car signal bundle between the group dispatcher and the two cars.
// Ports  : carK_floor/state/served/call_ready flow from the cars (K=0,1);
//          carK_call_valid/call_floor/call_up carry the offered hall call.
// master = dispatcher side, slave = car side.
interface elevator_group_dispatcher_if #(
  parameter int FLOOR_W = 3
);
  logic [FLOOR_W-1:0] car0_floor;
  logic [FLOOR_W-1:0] car1_floor;
  logic [1:0]         car0_state;
  logic [1:0]         car1_state;
  logic               car0_served;
  logic               car1_served;
  logic               car0_call_ready;
  logic               car1_call_ready;
  logic               car0_call_valid;
  logic               car1_call_valid;
  logic [FLOOR_W-1:0] car0_call_floor;
  logic [FLOOR_W-1:0] car1_call_floor;
  logic               car0_call_up;
  logic               car1_call_up;

  modport master (
    input  car0_floor, car1_floor, car0_state, car1_state,
    input  car0_served, car1_served, car0_call_ready, car1_call_ready,
    output car0_call_valid, car1_call_valid,
    output car0_call_floor, car1_call_floor, car0_call_up, car1_call_up
  );

  modport slave (
    output car0_floor, car1_floor, car0_state, car1_state,
    output car0_served, car1_served, car0_call_ready, car1_call_ready,
    input  car0_call_valid, car1_call_valid,
    input  car0_call_floor, car1_call_floor, car0_call_up, car1_call_up
  );
endinterface

// File: rtl/elevator_group_dispatcher.sv
// Purpose: latches hall up/down calls, assigns each to the cheaper of two cars,
//          and tracks it until the owning car reports it served.
// Latency: a press seen with the FSM idle is offered 4 edges later.
// Backpressure: the offer holds stable until the chosen car raises call_ready,
//          or is withdrawn if the call gets served meanwhile.
// Ports  : clk, rst (sync, active high); hall_up_btn/hall_down_btn [N:1] levels;
//          cars (master modport) per-car status in, call offer out;
//          led_up/led_down [N:1] call lamps; busy = dispatcher FSM not idle.
// Option : define ELEVATOR_DISPATCH_REASSIGN_EN to return calls that stay
//          assigned for AGE_LIMIT cycles back to the pending pool.
module elevator_group_dispatcher #(
  parameter int N         = 5,
  parameter int FLOOR_W   = 3,
  parameter int AGE_LIMIT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N:1]                  hall_up_btn,
  input  logic [N:1]                  hall_down_btn,
  elevator_group_dispatcher_if.master cars,
  output logic [N:1]                  led_up,
  output logic [N:1]                  led_down,
  output logic                        busy
);
  localparam int S  = 2 * N;
  localparam int IW = $clog2(S);
  localparam int CW = FLOOR_W + 2;
  localparam int LW = $clog2(S + 1);

  localparam logic [1:0] FREE = 2'd0, PEND = 2'd1, ASG0 = 2'd2, ASG1 = 2'd3;
  localparam logic [1:0] ST_WAIT = 2'd0, ST_OPEN = 2'd1, ST_DOWN = 2'd2, ST_UP = 2'd3;

  // Top-floor up and bottom-floor down buttons have no meaning; they are masked.
  localparam logic [S-1:0] LATCH_MASK = ~((S'(1) << (N - 1)) | (S'(1) << N));

  if ((1 << FLOOR_W) <= N || AGE_LIMIT < 1) begin : g_param_check
    $error("elevator_group_dispatcher: FLOOR_W too small or AGE_LIMIT < 1");
  end

  typedef enum logic [1:0] {IDLE, SCAN, COST, ISSUE} fsm_t;

  fsm_t          state_q, state_d;
  logic [1:0]    slot_q [S];
  logic [1:0]    slot_d [S];
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d;
  logic          win_q, win_d;
  logic          accept, live, any_pend, found, car1_wins;
  logic [S-1:0]  press;
  logic [CW-1:0] cost0, cost1;
  logic [LW-1:0] load0, load1;

  function automatic logic [FLOOR_W-1:0] slot_floor(input int s);
    return (s < N) ? FLOOR_W'(s + 1) : FLOOR_W'(s - N + 1);
  endfunction

  function automatic logic [CW-1:0] car_cost(input logic [FLOOR_W-1:0] cf,
                                             input logic [1:0]         cs,
                                             input logic [FLOOR_W-1:0] f,
                                             input logic               up);
    logic [CW-1:0] d, res;
    d   = (cf > f) ? CW'(cf - f) : CW'(f - cf);
    res = '1;
    case (cs)
      ST_WAIT: res = d;
      ST_OPEN: res = d + CW'(1);
      // A moving car standing at the call floor counts as heading toward it.
      ST_UP:   res = (f < cf) ? d + CW'(2 * N) : (up ? d : d + CW'(N));
      ST_DOWN: res = (f > cf) ? d + CW'(2 * N) : (up ? d + CW'(N) : d);
      default: res = '1;
    endcase
    if (cf == '0 || int'(cf) > N) res = '1;
    return res;
  endfunction

  assign press = {hall_down_btn, hall_up_btn} & LATCH_MASK;
  assign live  = (state_q == ISSUE) && (slot_q[idx_q] == PEND);
  assign busy  = (state_q != IDLE);

`ifdef ELEVATOR_DISPATCH_REASSIGN_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);
  logic [AW-1:0] age_q [S];

  always_ff @(posedge clk) begin
    for (int s = 0; s < S; s++) begin
      if (rst) age_q[s] <= '0;
      else     age_q[s] <= (slot_q[s][1] && slot_d[s][1]) ? age_q[s] + AW'(1) : '0;
    end
  end
`endif

  // Slot update order matters: assignment, then ageing, then served clears,
  // and a press last so that a press coinciding with a clear leaves PENDING.
  always_comb begin
    for (int s = 0; s < S; s++) begin
      slot_d[s] = slot_q[s];
      if (accept && IW'(s) == idx_q) slot_d[s] = win_q ? ASG1 : ASG0;
`ifdef ELEVATOR_DISPATCH_REASSIGN_EN
      if (slot_q[s][1] && age_q[s] == AW'(AGE_LIMIT)) slot_d[s] = PEND;
`endif
      if (cars.car0_served && slot_floor(s) == cars.car0_floor &&
          (slot_q[s] == PEND || slot_q[s] == ASG0)) slot_d[s] = FREE;
      if (cars.car1_served && slot_floor(s) == cars.car1_floor &&
          (slot_q[s] == PEND || slot_q[s] == ASG1)) slot_d[s] = FREE;
      if (press[s] && slot_d[s] == FREE) slot_d[s] = PEND;
    end
  end

  always_comb begin
    any_pend = 1'b0;
    load0    = '0;
    load1    = '0;
    for (int s = 0; s < S; s++) begin
      if (slot_q[s] == PEND) any_pend = 1'b1;
      if (slot_q[s] == ASG0) load0 = load0 + LW'(1);
      if (slot_q[s] == ASG1) load1 = load1 + LW'(1);
    end
    cost0 = car_cost(cars.car0_floor, cars.car0_state, slot_floor(int'(idx_q)), idx_q < IW'(N));
    cost1 = car_cost(cars.car1_floor, cars.car1_state, slot_floor(int'(idx_q)), idx_q < IW'(N));
    car1_wins = (cost1 < cost0) || ((cost1 == cost0) && (load1 < load0));
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    win_d   = win_q;
    accept  = 1'b0;
    found   = 1'b0;
    case (state_q)
      IDLE: if (any_pend) state_d = SCAN;
      SCAN: begin
        state_d = IDLE;
        // Round-robin from the pointer so one busy floor cannot starve others.
        for (int i = 0; i < S; i++) begin
          if (!found && slot_q[(int'(ptr_q) + i) % S] == PEND) begin
            found   = 1'b1;
            idx_d   = IW'((int'(ptr_q) + i) % S);
            state_d = COST;
          end
        end
      end
      COST: begin
        win_d   = car1_wins;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (!live) begin
          state_d = IDLE;
        end else if (win_q ? cars.car1_call_ready : cars.car0_call_ready) begin
          accept  = 1'b1;
          ptr_d   = (idx_q == IW'(S - 1)) ? '0 : idx_q + IW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      win_q    <= 1'b0;
      led_up   <= '0;
      led_down <= '0;
      for (int s = 0; s < S; s++) slot_q[s] <= FREE;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
      for (int s = 0; s < S; s++) slot_q[s] <= slot_d[s];
      for (int f = 1; f <= N; f++) begin
        led_up[f]   <= (slot_d[f-1] != FREE);
        led_down[f] <= (slot_d[N+f-1] != FREE);
      end
    end
  end

  assign cars.car0_call_valid = live && !win_q;
  assign cars.car1_call_valid = live && win_q;
  assign cars.car0_call_floor = cars.car0_call_valid ? slot_floor(int'(idx_q)) : '0;
  assign cars.car1_call_floor = cars.car1_call_valid ? slot_floor(int'(idx_q)) : '0;
  assign cars.car0_call_up    = cars.car0_call_valid && (idx_q < IW'(N));
  assign cars.car1_call_up    = cars.car1_call_valid && (idx_q < IW'(N));
endmodule
